// File: rtl/lfsr_param_if.sv
// Handshake/bus bundle for lfsr_param: control inputs from the master, LFSR state and status back from the slave.
interface lfsr_param_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             init;
  logic [WIDTH-1:0] initial_data;
  logic             mode;
  logic             start;
  logic [CNT_W-1:0] step_count;
  logic             free_run;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] steps;
  logic             period_hit;
  logic             lockup;

  modport master (
    output init, initial_data, mode, start, step_count, free_run,
    input  data_out, busy, done, steps, period_hit, lockup
  );

  modport slave (
    input  init, initial_data, mode, start, step_count, free_run,
    output data_out, busy, done, steps, period_hit, lockup
  );
endinterface

// File: rtl/lfsr_param.sv
// Parametrised Fibonacci/Galois LFSR with counted bursts, free-run, step counter and period detection.
// Optional all-zero lockup recovery is enabled by defining LFSR_LOCKUP_RECOVER_EN.
module lfsr_param #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int               CNT_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  lfsr_param_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           fsm_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] steps_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             hit_q;
  logic             step_en;
  logic             recover;

  function automatic logic [WIDTH-1:0] fib_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  // Recovery from the all-zero state replaces a step rather than counting as one.
  always_comb begin
    recover = 1'b0;
`ifdef LFSR_LOCKUP_RECOVER_EN
    recover = (lfsr_q == '0);
`endif
    step_en = 1'b0;
    case (fsm_q)
      S_RUN:   step_en = !recover;
      S_IDLE:  step_en = bus.free_run && !bus.start && !recover;
      default: step_en = 1'b0;
    endcase
    lfsr_d = bus.mode ? galois_step(lfsr_q) : fib_step(lfsr_q);
  end

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic lockup_q;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.init) begin
      lockup_q <= 1'b0;
    end else if (recover) begin
      lockup_q <= 1'b1;
    end
  end

  assign bus.lockup = lockup_q;
`else
  assign bus.lockup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      lfsr_q  <= SEED;
      ref_q   <= SEED;
      steps_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else if (bus.init) begin
      fsm_q   <= S_IDLE;
      lfsr_q  <= bus.initial_data;
      ref_q   <= bus.initial_data;
      steps_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      hit_q  <= 1'b0;
      if (recover) begin
        lfsr_q <= SEED;
      end else if (step_en) begin
        lfsr_q  <= lfsr_d;
        steps_q <= steps_q + WIDTH'(1);
        hit_q   <= (lfsr_d == ref_q);
      end
      case (fsm_q)
        S_IDLE: begin
          if (bus.start) begin
            cnt_q <= bus.step_count;
            if (bus.step_count == '0) begin
              fsm_q  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              fsm_q  <= S_RUN;
              busy_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!recover) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              fsm_q  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          fsm_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.data_out   = lfsr_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.steps      = steps_q;
  assign bus.period_hit = hit_q;

endmodule

// File: tb/tb_lfsr_param.sv
// Self-checking bench for lfsr_param: vector table, directed corner sequences and a randomized run against a reference model.
module tb_lfsr_param;
  localparam int         W      = 8;
  localparam int         CW     = 8;
  localparam logic [7:0] TAPS_V = 8'hB8;
  localparam logic [7:0] SEED_V = 8'h01;
`ifdef LFSR_LOCKUP_RECOVER_EN
  localparam bit REC = 1'b1;
`else
  localparam bit REC = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  lfsr_param_if #(.WIDTH(W), .CNT_W(CW)) bus_if ();

  lfsr_param #(.WIDTH(W), .TAPS(TAPS_V), .SEED(SEED_V), .CNT_W(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       init;
    logic [7:0] idata;
    logic       mode;
    logic       start;
    logic [7:0] n;
    logic       fr;
    logic [7:0] e_data;
    logic       e_busy;
    logic       e_done;
    logic [7:0] e_steps;
  } vec_t;

  vec_t vec [20];

  // reference model
  logic [7:0] m_s, m_ref, m_steps;
  int         m_left;
  bit         m_done, m_ph, m_lock;

  function automatic logic [7:0] nxt(input logic [7:0] s, input bit m);
    int si, ti, fb;
    si = int'(s);
    ti = int'(TAPS_V);
    fb = 0;
    if (m) return 8'((si / 2) ^ ((si % 2 == 1) ? ti : 0));
    for (int b = 0; b < W; b++)
      if ((((si >> b) & 1) == 1) && (((ti >> b) & 1) == 1)) fb++;
    return 8'(((si * 2) % (1 << W)) + (fb % 2));
  endfunction

  task automatic model_edge();
    bit do_step, rec, was_done;
    if (!rst_n || bus_if.init) begin
      m_s     = rst_n ? bus_if.initial_data : SEED_V;
      m_ref   = m_s;
      m_steps = 0;
      m_left  = 0;
      m_done  = 0;
      m_ph    = 0;
      m_lock  = 0;
      return;
    end
    do_step  = 0;
    was_done = m_done;
    rec      = REC && (m_s == 8'h00);
    m_done   = 0;
    m_ph     = 0;
    if (m_left > 0) begin
      if (!rec) begin
        do_step = 1;
        m_left--;
        if (m_left == 0) m_done = 1;
      end
    end else if (was_done) begin
      do_step = 0;
    end else if (bus_if.start) begin
      if (bus_if.step_count == 0) m_done = 1;
      else m_left = int'(bus_if.step_count);
    end else if (bus_if.free_run) begin
      do_step = 1;
    end
    if (rec) begin
      m_s    = SEED_V;
      m_lock = 1;
    end else if (do_step) begin
      m_s     = nxt(m_s, bus_if.mode);
      m_steps = m_steps + 8'd1;
      m_ph    = (m_s == m_ref);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic i, input logic [7:0] d, input logic m, input logic s,
                       input logic [7:0] n, input logic f);
    bus_if.init         = i;
    bus_if.initial_data = d;
    bus_if.mode         = m;
    bus_if.start        = s;
    bus_if.step_count   = n;
    bus_if.free_run     = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_v;
    int edges;
    bit seen;
    n_checks = 0;
    n_pass   = 0;

    vec[0]  = '{1, 8'h01, 0, 0, 8'd0, 0, 8'h01, 0, 0, 8'd0};
    vec[1]  = '{0, 8'h00, 0, 1, 8'd4, 0, 8'h01, 1, 0, 8'd0};
    vec[2]  = '{0, 8'h00, 0, 0, 8'd0, 0, 8'h02, 1, 0, 8'd1};
    vec[3]  = '{0, 8'h00, 0, 0, 8'd0, 0, 8'h04, 1, 0, 8'd2};
    vec[4]  = '{0, 8'h00, 0, 0, 8'd0, 0, 8'h08, 1, 0, 8'd3};
    vec[5]  = '{0, 8'h00, 0, 0, 8'd0, 0, 8'h11, 0, 1, 8'd4};
    vec[6]  = '{0, 8'h00, 0, 0, 8'd0, 0, 8'h11, 0, 0, 8'd4};
    vec[7]  = '{0, 8'h00, 0, 1, 8'd2, 0, 8'h11, 1, 0, 8'd4};
    vec[8]  = '{0, 8'h00, 0, 0, 8'd0, 0, 8'h23, 1, 0, 8'd5};
    vec[9]  = '{0, 8'h00, 0, 0, 8'd0, 0, 8'h47, 0, 1, 8'd6};
    vec[10] = '{0, 8'h00, 0, 0, 8'd0, 0, 8'h47, 0, 0, 8'd6};
    vec[11] = '{1, 8'h01, 1, 0, 8'd0, 0, 8'h01, 0, 0, 8'd0};
    vec[12] = '{0, 8'h00, 1, 1, 8'd4, 0, 8'h01, 1, 0, 8'd0};
    vec[13] = '{0, 8'h00, 1, 0, 8'd0, 0, 8'hB8, 1, 0, 8'd1};
    vec[14] = '{0, 8'h00, 1, 0, 8'd0, 0, 8'h5C, 1, 0, 8'd2};
    vec[15] = '{0, 8'h00, 1, 0, 8'd0, 0, 8'h2E, 1, 0, 8'd3};
    vec[16] = '{0, 8'h00, 1, 0, 8'd0, 0, 8'h17, 0, 1, 8'd4};
    vec[17] = '{0, 8'h00, 1, 1, 8'd3, 0, 8'h17, 0, 0, 8'd4};
    vec[18] = '{0, 8'h00, 1, 1, 8'd0, 0, 8'h17, 0, 1, 8'd4};
    vec[19] = '{0, 8'h00, 1, 0, 8'd0, 0, 8'h17, 0, 0, 8'd4};

    rst_n = 1'b0;
    drive(0, 8'h00, 0, 0, 8'd0, 0);
    tick();
    tick();
    chk("reset", {bus_if.data_out, bus_if.busy, bus_if.done, bus_if.steps, bus_if.period_hit, bus_if.lockup},
        {8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vec[i].init, vec[i].idata, vec[i].mode, vec[i].start, vec[i].n, vec[i].fr);
      tick();
      chk($sformatf("vec%0d", i), {bus_if.data_out, bus_if.busy, bus_if.done, bus_if.steps},
          {vec[i].e_data, vec[i].e_busy, vec[i].e_done, vec[i].e_steps});
    end

    // full period in free-run
    drive(1, 8'h01, 0, 0, 8'd0, 0);
    tick();
    drive(0, 8'h00, 0, 0, 8'd0, 1);
    for (int k = 1; k <= 255; k++) begin
      tick();
      chk($sformatf("period_hit_step%0d", k), bus_if.period_hit, (k == 255));
    end
    chk("period_end", {bus_if.data_out, bus_if.steps, bus_if.busy}, {8'h01, 8'hFF, 1'b0});
    drive(0, 8'h00, 0, 0, 8'd0, 0);
    tick();
    chk("period_hit_clear", bus_if.period_hit, 1'b0);

    // burst aborted by init, start ignored while busy
    drive(1, 8'h01, 0, 0, 8'd0, 0);
    tick();
    drive(0, 8'h00, 0, 1, 8'd10, 0);
    tick();
    chk("abort_busy", bus_if.busy, 1'b1);
    drive(0, 8'h00, 0, 1, 8'd2, 0);
    tick();
    drive(0, 8'h00, 0, 0, 8'd0, 0);
    tick();
    tick();
    chk("abort_step3", {bus_if.data_out, bus_if.busy, bus_if.steps}, {8'h08, 1'b1, 8'd3});
    drive(1, 8'h3C, 0, 0, 8'd0, 0);
    tick();
    chk("abort_init", {bus_if.data_out, bus_if.busy, bus_if.done, bus_if.steps}, {8'h3C, 1'b0, 1'b0, 8'd0});
    drive(0, 8'h00, 0, 0, 8'd0, 0);
    tick();
    chk("abort_nodone", {bus_if.busy, bus_if.done}, 2'b00);

    drive(0, 8'h00, 0, 1, 8'd5, 0);
    tick();
    drive(0, 8'h00, 0, 1, 8'd2, 0);
    edges = 0;
    seen  = 0;
    while (!seen && edges < 20) begin
      tick();
      edges++;
      seen = bus_if.done;
    end
    drive(0, 8'h00, 0, 0, 8'd0, 0);
    chk("burst_done_seen", seen, 1'b1);
    chk("burst_len", edges, 5);
    exp_v = 8'h3C;
    for (int k = 0; k < 5; k++) exp_v = nxt(exp_v, 1'b0);
    chk("burst_result", {bus_if.data_out, bus_if.steps}, {exp_v, 8'd5});
    tick();

    // all-zero state
    drive(1, 8'h00, 0, 0, 8'd0, 0);
    tick();
    chk("zero_init", {bus_if.data_out, bus_if.lockup}, {8'h00, 1'b0});
    drive(0, 8'h00, 0, 0, 8'd0, 1);
    tick();
`ifdef LFSR_LOCKUP_RECOVER_EN
    chk("zero_recover", {bus_if.data_out, bus_if.lockup, bus_if.steps}, {8'h01, 1'b1, 8'd0});
    tick();
    chk("zero_step1", {bus_if.data_out, bus_if.lockup, bus_if.steps}, {8'h02, 1'b1, 8'd1});
    tick();
    chk("zero_step2", {bus_if.data_out, bus_if.lockup}, {8'h04, 1'b1});
`else
    chk("zero_stuck0", {bus_if.data_out, bus_if.lockup, bus_if.steps}, {8'h00, 1'b0, 8'd1});
    tick();
    chk("zero_stuck1", {bus_if.data_out, bus_if.lockup, bus_if.steps}, {8'h00, 1'b0, 8'd2});
    tick();
    chk("zero_stuck2", {bus_if.data_out, bus_if.lockup}, {8'h00, 1'b0});
`endif
    drive(1, 8'h01, 0, 0, 8'd0, 0);
    tick();
    chk("lockup_cleared", {bus_if.data_out, bus_if.lockup}, {8'h01, 1'b0});

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n = (c == 0) ? 1'b0 : (($urandom % 200) != 0);
      drive(($urandom % 32) == 0,
            (($urandom % 4) == 0) ? 8'h00 : 8'($urandom % 256),
            1'($urandom % 2),
            ($urandom % 8) == 0,
            8'($urandom % 16),
            1'($urandom % 2));
      @(posedge clk);
      model_edge();
      #1;
      chk($sformatf("rand%0d", c),
          {bus_if.data_out, bus_if.busy, bus_if.done, bus_if.steps, bus_if.period_hit, bus_if.lockup},
          {m_s, (m_left > 0), m_done, m_steps, m_ph, m_lock});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
